alu_operand_sequencer: RTL and testbench

//   Front-end controller for the board-level ALU. Turns raw push-buttons and switches into
//   the operand/opcode registers that drive the ALU. Synchronises and debounces each button,

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_operand_sequencer_btn_debounce.sv | 64 ++++++
 rtl/alu_operand_sequencer.sv | 139 +++++++++++++
 tb/tb_alu_operand_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared state and button index constants for the ALU front end
//
// Purpose : state encoding of the operand sequencer and button bit positions,
//           used by the sequencer and by the ALU top level.
// Ports   : none (package)

package alu_pkg;

   // Sequencer states, as seen on o_state
   localparam logic [1:0] WAIT_A  = 2'd0;
   localparam logic [1:0] WAIT_B  = 2'd1;
   localparam logic [1:0] WAIT_OP = 2'd2;
   localparam logic [1:0] DONE    = 2'd3;

   // Bit positions within the button bus
   localparam int BTN_A  = 2;
   localparam int BTN_B  = 1;
   localparam int BTN_OP = 0;

endpackage

// File: rtl/alu_operand_sequencer_btn_debounce.sv
// rtl/alu_operand_sequencer_btn_debounce.sv - button synchroniser, debouncer and press detector
//
// Purpose : brings one raw asynchronous button into the clock domain, accepts a
//           new level only after it has been stable long enough, and emits a
//           one-cycle pulse on each accepted press.
// Ports   : clock   in  system clock
//           reset   in  asynchronous active-high reset
//           i_raw   in  raw button level
//           o_level out debounced level
//           o_press out one-cycle pulse on debounced 0->1

module btn_debounce #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic i_raw,
   output logic o_level,
   output logic o_press
);

   localparam int CNT_W = $clog2(DEB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic             prev_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The counter saturates at DEB_CYCLES; the level is only taken on the
   // following cycle if the input still disagrees. A pulse that is exactly
   // DEB_CYCLES cycles wide at the synchroniser output is therefore rejected.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_MAX) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         prev_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= i_raw;
         sync2_q <= sync1_q;
         level_q <= level_d;
         prev_q  <= level_q;
         cnt_q   <= cnt_d;
      end
   end

   assign o_level = level_q;
   assign o_press = level_q & ~prev_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// rtl/alu_operand_sequencer.sv - button-driven A/B/OP operand loader for the ALU
//
// Purpose : debounces three load buttons and sequences the loads A -> B -> OP,
//           flagging a complete operand set and out-of-order presses.
// Ports   : clock     in  system clock
//           reset     in  asynchronous active-high reset
//           i_SWs     in  switch value captured on a load
//           i_buttons in  raw buttons [2]=A [1]=B [0]=OP
//           o_A/o_B/o_OP out operand and opcode registers
//           o_valid   out high while in DONE
//           o_state   out sequencer state
//           o_err     out one-cycle pulse on out-of-order or multi-button press

module alu_operand_sequencer
   import alu_pkg::*;
#(
   parameter int N_SW       = 6,
   parameter int N_B        = 3,
   parameter int DEB_CYCLES = 4
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [N_SW-1:0] i_SWs,
   input  logic [N_B-1:0]  i_buttons,
   output logic [N_SW-1:0] o_A,
   output logic [N_SW-1:0] o_B,
   output logic [N_SW-1:0] o_OP,
   output logic            o_valid,
   output logic [1:0]      o_state,
   output logic            o_err
);

   logic [N_B-1:0]  btn_press;
   logic [N_B-1:0]  btn_level_unused;

   logic [1:0]      state_q, state_d;
   logic [N_SW-1:0] a_q, a_d, b_q, b_d, op_q, op_d;
   logic            valid_q, valid_d;
   logic            err_q, err_d;
   logic            multi;
   logic            p_a, p_b, p_op;

   for (genvar g = 0; g < N_B; g++) begin : g_btn
      btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
         .clock   (clock),
         .reset   (reset),
         .i_raw   (i_buttons[g]),
         .o_level (btn_level_unused[g]),
         .o_press (btn_press[g])
      );
   end

   // More than one bit set: clearing the lowest set bit leaves something
   assign multi = |(btn_press & (btn_press - 1'b1));
   assign p_a   = btn_press[BTN_A];
   assign p_b   = btn_press[BTN_B];
   assign p_op  = btn_press[BTN_OP];

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      err_d   = 1'b0;
      if (multi) begin
         err_d = 1'b1;
      end else begin
         case (state_q)
            WAIT_A: begin
               if (p_a) begin
                  a_d     = i_SWs;
                  state_d = WAIT_B;
               end else if (p_b || p_op) begin
                  err_d = 1'b1;
               end
            end
            WAIT_B: begin
               if (p_b) begin
                  b_d     = i_SWs;
                  state_d = WAIT_OP;
               end else if (p_a) begin
                  a_d = i_SWs;
               end else if (p_op) begin
                  err_d = 1'b1;
               end
            end
            WAIT_OP: begin
               if (p_op) begin
                  op_d    = i_SWs;
                  state_d = DONE;
               end else if (p_a) begin
                  a_d     = i_SWs;
                  state_d = WAIT_B;
               end else if (p_b) begin
                  b_d = i_SWs;
               end
            end
            default: begin
               // DONE: A restarts the sequence, B and OP are live edits
               if (p_a) begin
                  a_d     = i_SWs;
                  state_d = WAIT_B;
               end else if (p_b) begin
                  b_d = i_SWs;
               end else if (p_op) begin
                  op_d = i_SWs;
               end
            end
         endcase
      end
      valid_d = (state_d == DONE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= WAIT_A;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign o_A     = a_q;
   assign o_B     = b_q;
   assign o_OP    = op_q;
   assign o_valid = valid_q;
   assign o_state = state_q;
   assign o_err   = err_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb/tb_alu_operand_sequencer.sv - self-checking bench for alu_operand_sequencer

module tb_alu_operand_sequencer;

   localparam int DEB = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] sw    = '0;
   logic [2:0] btn   = '0;
   logic [5:0] o_A, o_B, o_OP;
   logic       o_valid, o_err;
   logic [1:0] o_state;

   int checks = 0;
   int errors = 0;
   int err_pulses = 0;

   alu_operand_sequencer #(.N_SW(6), .N_B(3), .DEB_CYCLES(DEB)) dut (
      .clock     (clock),
      .reset     (reset),
      .i_SWs     (sw),
      .i_buttons (btn),
      .o_A       (o_A),
      .o_B       (o_B),
      .o_OP      (o_OP),
      .o_valid   (o_valid),
      .o_state   (o_state),
      .o_err     (o_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   // Behavioural model: a press is recognised when the last DEB+1 raw samples,
   // seen through the two synchroniser stages, all disagree with the accepted
   // level; the FSM acts on it one edge later. Raw samples e-7..e-3 therefore
   // decide the action taken at edge e.
   logic [7:0] hist [3];
   bit         lvl  [3];
   logic [5:0] m_a, m_b, m_op;
   logic [1:0] m_s;
   bit         m_v, m_e;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int b = 0; b < 3; b++) begin
            hist[b] = '0;
            lvl[b]  = 0;
         end
         m_a = '0; m_b = '0; m_op = '0; m_s = 2'd0; m_v = 0; m_e = 0;
      end else begin
         bit p [3];
         int n;
         n = 0;
         for (int b = 0; b < 3; b++) begin
            hist[b] = {hist[b][6:0], btn[b]};
            p[b] = 0;
            if (hist[b][7:3] == 5'h1f && !lvl[b]) begin
               lvl[b] = 1;
               p[b]   = 1;
               n++;
            end else if (hist[b][7:3] == 5'h00 && lvl[b]) begin
               lvl[b] = 0;
            end
         end
         m_e = 0;
         if (n > 1) begin
            m_e = 1;
         end else if (n == 1) begin
            case (m_s)
               2'd0: if (p[2]) begin m_a = sw; m_s = 2'd1; end else m_e = 1;
               2'd1: if (p[1]) begin m_b = sw; m_s = 2'd2; end
                     else if (p[2]) m_a = sw;
                     else m_e = 1;
               2'd2: if (p[0]) begin m_op = sw; m_s = 2'd3; end
                     else if (p[2]) begin m_a = sw; m_s = 2'd1; end
                     else m_b = sw;
               default: if (p[2]) begin m_a = sw; m_s = 2'd1; end
                        else if (p[1]) m_b = sw;
                        else m_op = sw;
            endcase
         end
         m_v = (m_s == 2'd3);
      end
   end

   always @(negedge clock) begin
      if (!reset) begin
         chk("model_A", o_A, m_a);
         chk("model_B", o_B, m_b);
         chk("model_OP", o_OP, m_op);
         chk("model_state", o_state, m_s);
         chk("model_valid", o_valid, m_v);
         chk("model_err", o_err, m_e);
         if (o_err) err_pulses++;
      end
   end

   // Hold button b for 10 cycles; the state must still be st0 after 6 edges
   // and be st1 on the 7th edge after the first high sample.
   task automatic press(input int b, input logic [5:0] v, input logic [1:0] st0, input logic [1:0] st1);
      sw     = v;
      btn[b] = 1'b1;
      repeat (7) @(negedge clock);
      chk("latency_before", o_state, st0);
      @(negedge clock);
      chk("latency_at", o_state, st1);
      repeat (2) @(negedge clock);
      btn = '0;
      repeat (12) @(negedge clock);
   endtask

   initial begin
      int e0;
      repeat (3) @(negedge clock);
      chk("reset_state", o_state, 2'd0);
      chk("reset_valid", o_valid, 1'b0);
      chk("reset_A", o_A, 6'h00);
      reset = 1'b0;
      repeat (3) @(negedge clock);

      // 3- and 4-cycle glitches on A are rejected
      sw = 6'h11;
      btn[2] = 1'b1; repeat (3) @(negedge clock); btn = '0;
      repeat (12) @(negedge clock);
      btn[2] = 1'b1; repeat (4) @(negedge clock); btn = '0;
      repeat (12) @(negedge clock);
      chk("glitch_state", o_state, 2'd0);
      chk("glitch_A", o_A, 6'h00);

      // OP from WAIT_A: single error pulse
      e0 = err_pulses;
      press(0, 6'h2A, 2'd0, 2'd0);
      chk("op_first_err_pulses", err_pulses - e0, 1);
      chk("op_first_OP", o_OP, 6'h00);

      // A and B together: single error pulse, nothing loaded
      e0 = err_pulses;
      sw = 6'h15;
      btn = 3'b110;
      repeat (10) @(negedge clock);
      btn = '0;
      repeat (12) @(negedge clock);
      chk("multi_err_pulses", err_pulses - e0, 1);
      chk("multi_A", o_A, 6'h00);
      chk("multi_B", o_B, 6'h00);
      chk("multi_state", o_state, 2'd0);

      // Normal sequence
      press(2, 6'h05, 2'd0, 2'd1);
      chk("seq_A", o_A, 6'h05);
      press(1, 6'h0A, 2'd1, 2'd2);
      chk("seq_B", o_B, 6'h0A);
      chk("seq_valid_pre", o_valid, 1'b0);
      press(0, 6'h20, 2'd2, 2'd3);
      chk("seq_OP", o_OP, 6'h20);
      chk("seq_valid", o_valid, 1'b1);

      // Live OP edit, then restart
      press(0, 6'h21, 2'd3, 2'd3);
      chk("edit_OP", o_OP, 6'h21);
      chk("edit_valid", o_valid, 1'b1);
      press(2, 6'h3F, 2'd3, 2'd1);
      chk("restart_A", o_A, 6'h3F);
      chk("restart_valid", o_valid, 1'b0);
      chk("restart_B", o_B, 6'h0A);
      chk("restart_OP", o_OP, 6'h21);

      // Reset while B is mid-debounce
      sw = 6'h07;
      btn[1] = 1'b1;
      repeat (4) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      chk("async_A", o_A, 6'h00);
      chk("async_B", o_B, 6'h00);
      chk("async_OP", o_OP, 6'h00);
      chk("async_state", o_state, 2'd0);
      chk("async_valid", o_valid, 1'b0);
      chk("async_err", o_err, 1'b0);
      @(negedge clock);
      reset = 1'b0;
      repeat (7) @(negedge clock);
      chk("post_reset_err_early", o_err, 1'b0);
      @(negedge clock);
      chk("post_reset_err", o_err, 1'b1);
      chk("post_reset_state", o_state, 2'd0);
      @(negedge clock);
      chk("post_reset_err_end", o_err, 1'b0);
      btn = '0;
      repeat (12) @(negedge clock);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
